// File: rtl/iterative_divider.sv
// -----------------------------------------------------------------------------
// iterative_divider
//   Sequential restoring divider. It divides a 2*DATAWIDTH dividend (typically
//   an array-multiplier product) by a DATAWIDTH divisor. The result is a
//   DATAWIDTH quotient and remainder after DATAWIDTH iteration cycles.
//   Divide-by-zero and quotient overflow are detected at accept time. Both
//   finish in one cycle with Q = all ones and R = low half of the dividend.
//
// Parameters
//   DATAWIDTH    operand width (>= 2); dividend is 2*DATAWIDTH wide
//   INSTANCE_ID  instance tag, no functional effect
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   i_valid  in   dividend/divisor present
//   i_ready  out  divider can accept (high only when idle)
//   Z        in   dividend, 2*DATAWIDTH
//   D        in   divisor, DATAWIDTH
//   o_valid  out  one-cycle pulse, Q/R/flags valid
//   Q        out  quotient
//   R        out  remainder
//   o_dbz    out  divide-by-zero flag (qualified by o_valid)
//   o_ovf    out  quotient-overflow flag (qualified by o_valid)
// -----------------------------------------------------------------------------
module iterative_divider #(
    parameter int DATAWIDTH   = 4,
    parameter int INSTANCE_ID = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [2*DATAWIDTH-1:0] Z,
    input  logic [DATAWIDTH-1:0]   D,
    output logic                   o_valid,
    output logic [DATAWIDTH-1:0]   Q,
    output logic [DATAWIDTH-1:0]   R,
    output logic                   o_dbz,
    output logic                   o_ovf
);

    localparam int CW = $clog2(DATAWIDTH + 1);

    // The instance tag only identifies the block in the netlist.
    if (INSTANCE_ID < 0) begin : g_instance_tag
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    // The partial remainder is always below the divisor after each step. Its
    // extra top bit is therefore only needed transiently in w_shift.
    logic [DATAWIDTH-1:0]   r_p;
    logic [DATAWIDTH-1:0]   w_p_next;
    logic [DATAWIDTH-1:0]   r_qsr;
    logic [DATAWIDTH-1:0]   w_qsr_next;
    logic [DATAWIDTH-1:0]   r_d;
    logic [DATAWIDTH-1:0]   w_d_next;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_next;
    logic [DATAWIDTH-1:0]   r_q;
    logic [DATAWIDTH-1:0]   w_q_next;
    logic [DATAWIDTH-1:0]   r_r;
    logic [DATAWIDTH-1:0]   w_r_next;
    logic                   r_dbz;
    logic                   w_dbz_next;
    logic                   r_ovf;
    logic                   w_ovf_next;
    logic                   r_ready;
    logic                   r_valid;

    // One restoring step: the shifted remainder is compared with the divisor.
    logic [DATAWIDTH:0]     w_shift;
    logic                   w_ge;
    logic [DATAWIDTH-1:0]   w_sub;
    logic [DATAWIDTH-1:0]   w_p_iter;
    logic [DATAWIDTH-1:0]   w_qsr_iter;

    assign w_shift    = {r_p, r_qsr[DATAWIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_d});
    // When w_ge holds, the true difference is < r_d, so DATAWIDTH bits suffice.
    assign w_sub      = w_shift[DATAWIDTH-1:0] - r_d;
    assign w_p_iter   = w_ge ? w_sub : w_shift[DATAWIDTH-1:0];
    assign w_qsr_iter = {r_qsr[DATAWIDTH-2:0], w_ge};

    // Next-state and datapath-next logic; every target holds by default.
    always_comb begin
        w_state_next = r_state;
        w_p_next     = r_p;
        w_qsr_next   = r_qsr;
        w_d_next     = r_d;
        w_cnt_next   = r_cnt;
        w_q_next     = r_q;
        w_r_next     = r_r;
        w_dbz_next   = r_dbz;
        w_ovf_next   = r_ovf;
        case (r_state)
            ST_IDLE: begin
                if (i_valid) begin
                    if (D == {DATAWIDTH{1'b0}}) begin
                        w_q_next     = {DATAWIDTH{1'b1}};
                        w_r_next     = Z[DATAWIDTH-1:0];
                        w_dbz_next   = 1'b1;
                        w_ovf_next   = 1'b0;
                        w_state_next = ST_DONE;
                    end else if (Z[2*DATAWIDTH-1:DATAWIDTH] >= D) begin
                        // Quotient would not fit in DATAWIDTH bits.
                        w_q_next     = {DATAWIDTH{1'b1}};
                        w_r_next     = Z[DATAWIDTH-1:0];
                        w_dbz_next   = 1'b0;
                        w_ovf_next   = 1'b1;
                        w_state_next = ST_DONE;
                    end else begin
                        w_p_next     = Z[2*DATAWIDTH-1:DATAWIDTH];
                        w_qsr_next   = Z[DATAWIDTH-1:0];
                        w_d_next     = D;
                        w_cnt_next   = {CW{1'b0}};
                        w_state_next = ST_CALC;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CALC: begin
                w_p_next   = w_p_iter;
                w_qsr_next = w_qsr_iter;
                w_cnt_next = r_cnt + CW'(1);
                if (r_cnt == CW'(DATAWIDTH - 1)) begin
                    w_q_next     = w_qsr_iter;
                    w_r_next     = w_p_iter;
                    w_dbz_next   = 1'b0;
                    w_ovf_next   = 1'b0;
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_CALC;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake/result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_p     <= {DATAWIDTH{1'b0}};
            r_qsr   <= {DATAWIDTH{1'b0}};
            r_d     <= {DATAWIDTH{1'b0}};
            r_cnt   <= {CW{1'b0}};
            r_q     <= {DATAWIDTH{1'b0}};
            r_r     <= {DATAWIDTH{1'b0}};
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_p     <= w_p_next;
            r_qsr   <= w_qsr_next;
            r_d     <= w_d_next;
            r_cnt   <= w_cnt_next;
            r_q     <= w_q_next;
            r_r     <= w_r_next;
            r_dbz   <= w_dbz_next;
            r_ovf   <= w_ovf_next;
            r_ready <= (w_state_next == ST_IDLE);
            r_valid <= (w_state_next == ST_DONE);
        end
    end

    assign i_ready = r_ready;
    assign o_valid = r_valid;
    assign Q       = r_q;
    assign R       = r_r;
    assign o_dbz   = r_dbz;
    assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_iterative_divider.sv
module tb_iterative_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    // DATAWIDTH = 4 instance
    logic       iv4, rdy4, ov4, dbz4, ovf4;
    logic [7:0] z4;
    logic [3:0] d4, q4, r4;
    // DATAWIDTH = 8 instance (multiplier chain)
    logic        iv8, rdy8, ov8, dbz8, ovf8;
    logic [15:0] z8;
    logic [7:0]  d8, q8, r8;

    int n_cmp  = 0;
    int n_fail = 0;

    iterative_divider #(.DATAWIDTH(4), .INSTANCE_ID(0)) u_dut4 (
        .clk(clk), .rst(rst), .i_valid(iv4), .i_ready(rdy4), .Z(z4), .D(d4),
        .o_valid(ov4), .Q(q4), .R(r4), .o_dbz(dbz4), .o_ovf(ovf4)
    );

    iterative_divider #(.DATAWIDTH(8), .INSTANCE_ID(1)) u_dut8 (
        .clk(clk), .rst(rst), .i_valid(iv8), .i_ready(rdy8), .Z(z8), .D(d8),
        .o_valid(ov8), .Q(q8), .R(r8), .o_dbz(dbz8), .o_ovf(ovf8)
    );

    typedef struct {
        logic [7:0] z;
        logic [3:0] d;
        logic [3:0] q;
        logic [3:0] r;
        logic       dbz;
        logic       ovf;
        int         lat;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one operation on the 4-bit DUT and return cycles from accept to o_valid.
    task automatic run4(input logic [7:0] z, input logic [3:0] d, output int lat);
        int n;
        @(negedge clk);
        z4 = z; d4 = d; iv4 = 1'b1;
        n = 0;
        while (!rdy4 && n < 50) begin @(negedge clk); n++; end
        check("accept4", {31'd0, rdy4}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        iv4 = 1'b0;
        lat = 1;
        while (!ov4 && lat < 50) begin @(negedge clk); lat++; end
        check("done4", {31'd0, ov4}, 32'd1);
    endtask

    task automatic run8(input logic [15:0] z, input logic [7:0] d, output int lat);
        int n;
        @(negedge clk);
        z8 = z; d8 = d; iv8 = 1'b1;
        n = 0;
        while (!rdy8 && n < 50) begin @(negedge clk); n++; end
        check("accept8", {31'd0, rdy8}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 50) begin @(negedge clk); lat++; end
        check("done8", {31'd0, ov8}, 32'd1);
    endtask

    initial begin
        int lat;
        int seen;
        logic [3:0] rdy_seq;
        int a, b, zz, dd;

        vecs[0]  = '{8'h5B, 4'd7,  4'hD, 4'h0, 1'b0, 1'b0, 5};
        vecs[1]  = '{8'h64, 4'd9,  4'hB, 4'h1, 1'b0, 1'b0, 5};
        vecs[2]  = '{8'h90, 4'd9,  4'hF, 4'h0, 1'b0, 1'b1, 1};
        vecs[3]  = '{8'h3C, 4'd0,  4'hF, 4'hC, 1'b1, 1'b0, 1};
        vecs[4]  = '{8'h2A, 4'd6,  4'h7, 4'h0, 1'b0, 1'b0, 5};
        vecs[5]  = '{8'hFF, 4'd15, 4'hF, 4'hF, 1'b0, 1'b1, 1};
        vecs[6]  = '{8'hEF, 4'd15, 4'hF, 4'hE, 1'b0, 1'b0, 5};
        vecs[7]  = '{8'h00, 4'd1,  4'h0, 4'h0, 1'b0, 1'b0, 5};
        vecs[8]  = '{8'h0F, 4'd1,  4'hF, 4'h0, 1'b0, 1'b0, 5};
        vecs[9]  = '{8'h7F, 4'd8,  4'hF, 4'h7, 1'b0, 1'b0, 5};
        vecs[10] = '{8'h35, 4'd4,  4'hD, 4'h1, 1'b0, 1'b0, 5};
        vecs[11] = '{8'h00, 4'd0,  4'hF, 4'h0, 1'b1, 1'b0, 1};
        vecs[12] = '{8'h12, 4'd3,  4'h6, 4'h0, 1'b0, 1'b0, 5};
        vecs[13] = '{8'h81, 4'd8,  4'hF, 4'h1, 1'b0, 1'b1, 1};

        rst = 1'b1; iv4 = 1'b0; z4 = 8'd0; d4 = 4'd0;
        iv8 = 1'b0; z8 = 16'd0; d8 = 8'd0;
        #12;
        check("rst_ready", {31'd0, rdy4}, 32'd1);
        check("rst_valid", {31'd0, ov4}, 32'd0);
        check("rst_q", {28'd0, q4}, 32'd0);
        check("rst_r", {28'd0, r4}, 32'd0);
        check("rst_dbz", {31'd0, dbz4}, 32'd0);
        check("rst_ovf", {31'd0, ovf4}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 14; i++) begin
            run4(vecs[i].z, vecs[i].d, lat);
            check($sformatf("v%0d_q", i), {28'd0, q4}, {28'd0, vecs[i].q});
            check($sformatf("v%0d_r", i), {28'd0, r4}, {28'd0, vecs[i].r});
            check($sformatf("v%0d_dbz", i), {31'd0, dbz4}, {31'd0, vecs[i].dbz});
            check($sformatf("v%0d_ovf", i), {31'd0, ovf4}, {31'd0, vecs[i].ovf});
            check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            @(negedge clk);
            check($sformatf("v%0d_pulse", i), {31'd0, ov4}, 32'd0);
            check($sformatf("v%0d_hold_q", i), {28'd0, q4}, {28'd0, vecs[i].q});
        end

        // i_ready low for exactly 5 cycles; held i_valid re-accepted on return
        @(negedge clk);
        z4 = 8'h64; d4 = 4'd9; iv4 = 1'b1;
        check("bp_ready_before", {31'd0, rdy4}, 32'd1);
        @(posedge clk);
        rdy_seq = 4'd0;
        seen = 0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (rdy4) seen++;
            if (k == 5) begin
                check("bp_valid_c5", {31'd0, ov4}, 32'd1);
                check("bp_q", {28'd0, q4}, 32'd11);
                check("bp_r", {28'd0, r4}, 32'd1);
                z4 = 8'h2A; d4 = 4'd6;
            end
        end
        check("bp_ready_low_cnt", seen, 0);
        @(negedge clk);
        check("bp_ready_back", {31'd0, rdy4}, 32'd1);
        @(negedge clk);
        check("bp_reaccepted", {31'd0, rdy4}, 32'd0);
        iv4 = 1'b0;
        lat = 1;
        while (!ov4 && lat < 50) begin @(negedge clk); lat++; end
        check("bp2_lat", lat, 5);
        check("bp2_q", {28'd0, q4}, 32'd7);
        check("bp2_r", {28'd0, r4}, 32'd0);

        // Async reset two iterations into CALC
        @(negedge clk);
        @(negedge clk);
        z4 = 8'h5B; d4 = 4'd7; iv4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("ar_q", {28'd0, q4}, 32'd0);
        check("ar_r", {28'd0, r4}, 32'd0);
        check("ar_valid", {31'd0, ov4}, 32'd0);
        check("ar_ready", {31'd0, rdy4}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ov4) seen++;
        end
        check("ar_no_valid", seen, 0);
        run4(8'h2A, 4'd6, lat);
        check("ar_next_q", {28'd0, q4}, 32'd7);
        check("ar_next_r", {28'd0, r4}, 32'd0);
        check("ar_next_lat", lat, 5);

        // Multiplier chain at DATAWIDTH = 8: (A*B)/B == A, remainder 0
        for (int i = 0; i < 8; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(1, 255));
            run8(16'(a * b), 8'(b), lat);
            check($sformatf("chain%0d_q", i), {24'd0, q8}, a);
            check($sformatf("chain%0d_r", i), {24'd0, r8}, 32'd0);
            check($sformatf("chain%0d_lat", i), lat, 9);
        end

        // Random dividends with Z_hi < D: invariant Q*D+R == Z and R < D
        for (int i = 0; i < 8; i++) begin
            dd = int'($urandom_range(1, 255));
            zz = int'($urandom_range(0, dd - 1)) * 256 + int'($urandom_range(0, 255));
            run8(16'(zz), 8'(dd), lat);
            check($sformatf("inv%0d_qdr", i), int'(q8) * dd + int'(r8), zz);
            check($sformatf("inv%0d_rltd", i), {31'd0, (int'(r8) < dd)}, 32'd1);
            check($sformatf("inv%0d_q", i), {24'd0, q8}, zz / dd);
            check($sformatf("inv%0d_flags", i), {30'd0, dbz8, ovf8}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
